raster_tri_sched: RTL and testbench
===================================

// Module: raster_tri_sched
// PURPOSE
//  Sequences the bounding_box datapath for a stream of triangles. Accepts one
//  144-bit triangle over a valid/ready handshake and fires a one-cycle bb_en.
//  It then waits for bb_valid and latches the four integer bounds. Finally it
//  scans every pixel (x,y) inside the box, row-major, to the downstream
//  edge-test stage over a second valid/ready handshake.
//  Sits between the triangle input FIFO and the per-pixel edge-function unit.
// PARAMETERS
//  COORD_W     16  width of integer pixel coordinates (matches bounding_box ints)
//  TIMEOUT_CYC 64  max cycles in WAIT_BB before declaring bb_timeout
//  CNT_W       16  width of completed-triangle counter
// PORTS
//  clk           in   1        system clock, rising edge
//  areset        in   1        asynchronous, active-high reset
//  tri_in        in   144      triangle {v0x,v0y,v0z,v1x,..,v2z}, fp16 each
//  tri_in_valid  in   1        tri_in holds a triangle
//  tri_in_ready  out  1        scheduler will accept tri_in this cycle
//  bb_en         out  1        one-cycle start pulse to bounding_box
//  bb_triangle   out  144      triangle to bounding_box; stable from LAUNCH until SCAN exit
//  bb_x_min/bb_x_max/bb_y_min/bb_y_max  in  COORD_W  integer bounds from bounding_box
//  bb_valid      in   1        bounds valid (single-cycle pulse)
//  pix_x, pix_y  out  COORD_W  current pixel coordinate
//  pix_valid     out  1        pix_x/pix_y valid
//  pix_ready     in   1        downstream accepts pixel
//  pix_last      out  1        current pixel is last of this triangle
//  tri_done      out  1        one-cycle pulse: triangle fully retired
//  busy          out  1        state != IDLE
//  tri_count     out  CNT_W    triangles retired since reset, wraps at 2^CNT_W
//  bb_timeout    out  1        sticky: WAIT_BB exceeded TIMEOUT_CYC
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal regs 0. areset mid-operation aborts
//   immediately. No pixel or tri_done may appear after areset is released
//   until a new triangle is accepted.
//  FSM (enum in pkg): IDLE, LAUNCH, WAIT_BB, SCAN.
//  IDLE: tri_in_ready=1. On tri_in_valid, latch tri_in into bb_triangle -> LAUNCH.
//  LAUNCH: bb_en=1 for exactly this one cycle; clear wait counter -> WAIT_BB.
//  WAIT_BB: wait counter increments each cycle.
//   - bb_valid: latch the 4 bounds; x=x_min, y=y_min.
//     -> SCAN if x_min<=x_max and y_min<=y_max (unsigned compare).
//     -> otherwise the triangle is degenerate: tri_done pulse, tri_count++, -> IDLE.
//   - counter reaches TIMEOUT_CYC-1 without bb_valid: set bb_timeout
//     (cleared only by reset), tri_done pulse, no tri_count change, -> IDLE.
//   - bb_valid arriving in any other state is ignored.
//  SCAN: pix_valid=1; pix_x/pix_y come straight from registers.
//   pix_last = (x==x_max && y==y_max).
//   On pix_valid&&pix_ready:
//     - not last: if x==x_max then x=x_min, y++; else x++.
//     - last: tri_done pulse, tri_count++, -> IDLE.
//   While pix_ready=0: hold pix_x/pix_y/pix_valid/pix_last stable.
//  Throughput: 1 pixel/cycle with pix_ready held high.
//   Single-pixel box: 1 SCAN cycle. Back-to-back: IDLE accept costs 1 cycle.
//  tri_done is registered: asserts the cycle after the retiring event.
//  Arithmetic: x,y are COORD_W unsigned; x_max=0xFFFF must not wrap.
//   x compares before increment.
// STRUCTURE
//  rast_pkg: sched_state_t enum, TRI_W=144, FP16_W=16 constants.
//  One sub-module: rast_scan_ctr (x/y row-major counter with load, step,
//   last output). Everything else inline.
// TESTING
//  1) Triangle -> bb_valid 11 cyc later with bounds x 2..4, y 7..8, pix_ready=1
//     -> 6 pixels (2,7),(3,7),(4,7),(2,8),(3,8),(4,8); pix_last on (4,8);
//     tri_done 1 cyc later; tri_count=1.
//  2) Same bounds, pix_ready toggles 1,0,0,1,...
//     -> pix_x/pix_y stable during stalls, still exactly 6 handshakes, no drops.
//  3) Bounds x 5..5, y 0..0 -> one pixel (5,0) with pix_last=1.
//     Bounds x_min=9, x_max=3 -> zero pixels, tri_done, tri_count++.
//  4) bb_valid never returns -> bb_timeout=1 after 64 WAIT_BB cycles,
//     tri_done pulse, tri_count unchanged, next triangle still processed.
//  5) Assert areset during SCAN at pixel 3 of 6
//     -> all outputs 0 same cycle, state IDLE, no further pixels.
//     Next triangle then scans correctly.
//  6) tri_in_valid held high with 3 queued triangles
//     -> exactly one bb_en per triangle, tri_in_ready only in IDLE, tri_count=3.

Source files
------------

// File: rtl/rast_pkg.sv
// Shared types and widths for the triangle raster scheduler.
package rast_pkg;
  localparam int FP16_W = 16;
  localparam int TRI_W  = 9 * FP16_W;  // {v0x,v0y,v0z,v1x,..,v2z}

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BB, SCAN} sched_state_t;
endpackage

// File: rtl/rast_scan_ctr.sv
// Row-major x/y pixel walker over a latched bounding box.
// The x compare happens before any increment, so x_max = all-ones never wraps.
module rast_scan_ctr #(
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               load,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  input  logic               step,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);
  logic [COORD_W-1:0] x_lo, x_hi, y_hi;
  logic               x_end;

  assign x_end = (x == x_hi);
  assign last  = x_end && (y == y_hi);

  // Load box corners and start position; step wraps x back to x_lo at row end.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      x_lo <= '0;
      x_hi <= '0;
      y_hi <= '0;
      x    <= '0;
      y    <= '0;
    end else if (load) begin
      x_lo <= x_min;
      x_hi <= x_max;
      y_hi <= y_max;
      x    <= x_min;
      y    <= y_min;
    end else if (step) begin
      if (x_end) begin
        x <= x_lo;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end
endmodule

// File: rtl/raster_tri_sched.sv
// Triangle scheduler: accept a triangle, kick bounding_box, wait for bounds,
// then stream every pixel of the box row-major to the edge-test stage.
module raster_tri_sched import rast_pkg::*; #(
  parameter int COORD_W     = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               areset,
  input  logic [TRI_W-1:0]   tri_in,
  input  logic               tri_in_valid,
  output logic               tri_in_ready,
  output logic               bb_en,
  output logic [TRI_W-1:0]   bb_triangle,
  input  logic [COORD_W-1:0] bb_x_min,
  input  logic [COORD_W-1:0] bb_x_max,
  input  logic [COORD_W-1:0] bb_y_min,
  input  logic [COORD_W-1:0] bb_y_max,
  input  logic               bb_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic               tri_done,
  output logic               busy,
  output logic [CNT_W-1:0]   tri_count,
  output logic               bb_timeout
);
  localparam int WC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  sched_state_t    state;
  logic [WC_W-1:0] wait_cnt;
  logic            accept, bb_load, bb_ok, step, last;

  // tri_in_ready is only ever high in IDLE, so it doubles as the accept gate.
  assign accept   = tri_in_ready && tri_in_valid;
  assign bb_load  = (state == WAIT_BB) && bb_valid;
  assign bb_ok    = (bb_x_min <= bb_x_max) && (bb_y_min <= bb_y_max);
  assign step     = pix_valid && pix_ready && !last;
  assign pix_last = pix_valid && last;

  rast_scan_ctr #(.COORD_W(COORD_W)) u_scan (
    .clk    (clk),
    .areset (areset),
    .load   (bb_load),
    .x_min  (bb_x_min),
    .x_max  (bb_x_max),
    .y_min  (bb_y_min),
    .y_max  (bb_y_max),
    .step   (step),
    .x      (pix_x),
    .y      (pix_y),
    .last   (last)
  );

  // Scheduler FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      tri_in_ready <= 1'b0;
      bb_en        <= 1'b0;
      bb_triangle  <= '0;
      pix_valid    <= 1'b0;
      tri_done     <= 1'b0;
      busy         <= 1'b0;
      tri_count    <= '0;
      bb_timeout   <= 1'b0;
    end else begin
      bb_en    <= 1'b0;
      tri_done <= 1'b0;
      case (state)
        IDLE: begin
          tri_in_ready <= 1'b1;
          if (accept) begin
            bb_triangle  <= tri_in;
            tri_in_ready <= 1'b0;
            bb_en        <= 1'b1;
            busy         <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          wait_cnt <= '0;
          state    <= WAIT_BB;
        end
        WAIT_BB: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (bb_valid) begin
            if (bb_ok) begin
              pix_valid <= 1'b1;
              state     <= SCAN;
            end else begin
              // empty box: retire without emitting pixels
              tri_done     <= 1'b1;
              tri_count    <= tri_count + 1'b1;
              busy         <= 1'b0;
              tri_in_ready <= 1'b1;
              state        <= IDLE;
            end
          end else if (wait_cnt == WC_W'(TIMEOUT_CYC - 1)) begin
            bb_timeout   <= 1'b1;
            tri_done     <= 1'b1;
            busy         <= 1'b0;
            tri_in_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        SCAN: begin
          if (pix_ready && last) begin
            pix_valid    <= 1'b0;
            tri_done     <= 1'b1;
            tri_count    <= tri_count + 1'b1;
            busy         <= 1'b0;
            tri_in_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_raster_tri_sched.sv
// Randomized bench for raster_tri_sched with a queue-based pixel/retire model.
module tb_raster_tri_sched;
  localparam int CW  = 16;
  localparam int NW  = 16;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            areset;
  logic [143:0]    tri_in;
  logic            tri_in_valid, tri_in_ready, bb_en;
  logic [143:0]    bb_triangle;
  logic [CW-1:0]   bb_x_min, bb_x_max, bb_y_min, bb_y_max;
  logic            bb_valid;
  logic [CW-1:0]   pix_x, pix_y;
  logic            pix_valid, pix_ready, pix_last, tri_done, busy;
  logic [NW-1:0]   tri_count;
  logic            bb_timeout;

  always #5 clk = ~clk;

  raster_tri_sched #(.COORD_W(CW), .TIMEOUT_CYC(TMO), .CNT_W(NW)) dut (
    .clk(clk), .areset(areset), .tri_in(tri_in), .tri_in_valid(tri_in_valid),
    .tri_in_ready(tri_in_ready), .bb_en(bb_en), .bb_triangle(bb_triangle),
    .bb_x_min(bb_x_min), .bb_x_max(bb_x_max), .bb_y_min(bb_y_min), .bb_y_max(bb_y_max),
    .bb_valid(bb_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .tri_done(tri_done), .busy(busy),
    .tri_count(tri_count), .bb_timeout(bb_timeout)
  );

  typedef struct { int x; int y; bit last; } pix_t;
  typedef struct { int xmin; int xmax; int ymin; int ymax; int dly; bit resp; bit spur; } cfg_t;

  int   checks = 0, fails = 0;
  pix_t expq[$];
  pix_t obs[$];
  cfg_t cfgq[$];
  cfg_t rc;

  // model state
  bit           in_wait, due_done, due_inc, due_tmo, en_due, m_tmo;
  bit           nd, ni, nt;
  int           wcyc, retired, m_count, en_cnt;
  logic [143:0] acc_tri;
  bit           p_valid, p_ready;
  logic [CW-1:0] p_x, p_y;
  logic         p_last;
  int           rdy_mode = 0;
  int           pat = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: model of pixels, retire timing, count and timeout.
  always @(negedge clk) begin
    if (areset) begin
      chk("reset_outputs", {tri_in_ready, bb_en, bb_triangle, pix_x, pix_y, pix_valid,
                            pix_last, tri_done, busy, tri_count, bb_timeout}, '0);
      expq.delete();
      in_wait = 0; due_done = 0; due_inc = 0; due_tmo = 0; en_due = 0;
      m_count = 0; m_tmo = 0; p_valid = 0; p_ready = 0;
    end else begin
      if (due_done) begin
        retired++;
        if (due_inc) m_count++;
        if (due_tmo) m_tmo = 1;
      end
      chk("tri_done", tri_done, due_done);
      chk("tri_count", tri_count, m_count[NW-1:0]);
      chk("bb_timeout", bb_timeout, m_tmo);
      nd = 0; ni = 0; nt = 0;
      chk("bb_en", bb_en, en_due);
      if (en_due && bb_en) chk("bb_triangle", bb_triangle, acc_tri);
      if (bb_en) en_cnt++;
      chk("ready_busy_excl", tri_in_ready & busy, 0);
      if (in_wait) begin
        wcyc++;
        if (bb_valid) begin
          in_wait = 0;
          if (bb_x_min <= bb_x_max && bb_y_min <= bb_y_max) begin
            for (int y = int'(bb_y_min); y <= int'(bb_y_max); y++)
              for (int x = int'(bb_x_min); x <= int'(bb_x_max); x++)
                expq.push_back('{x, y, 1'b0});
            expq[expq.size()-1].last = 1'b1;
          end else begin
            nd = 1; ni = 1;
          end
        end else if (wcyc == TMO) begin
          in_wait = 0; nd = 1; nt = 1;
        end
      end
      if (bb_en) begin in_wait = 1; wcyc = 0; end
      en_due = tri_in_valid && tri_in_ready;
      if (en_due) acc_tri = tri_in;
      if (p_valid && !p_ready)
        chk("stall_hold", {pix_valid, pix_x, pix_y, pix_last}, {1'b1, p_x, p_y, p_last});
      if (pix_valid) begin
        if (expq.size() == 0) chk("pix_unexpected", 1, 0);
        else begin
          chk("pix_xy_last", {pix_x, pix_y, pix_last},
              {expq[0].x[CW-1:0], expq[0].y[CW-1:0], expq[0].last});
          if (pix_ready) begin
            obs.push_back('{int'(pix_x), int'(pix_y), pix_last});
            if (expq[0].last) begin nd = 1; ni = 1; end
            void'(expq.pop_front());
          end
        end
      end
      p_valid = pix_valid; p_ready = pix_ready; p_x = pix_x; p_y = pix_y; p_last = pix_last;
      due_done = nd; due_inc = ni; due_tmo = nt;
    end
  end

  // bounding_box stand-in: answers each bb_en from the config queue.
  initial begin
    bb_valid = 0; bb_x_min = '0; bb_x_max = '0; bb_y_min = '0; bb_y_max = '0;
    forever begin
      @(negedge clk);
      if (bb_en && !areset && cfgq.size() > 0) begin
        rc = cfgq.pop_front();
        if (rc.resp) begin
          repeat (rc.dly) @(posedge clk);
          #1;
          bb_x_min = rc.xmin[CW-1:0]; bb_x_max = rc.xmax[CW-1:0];
          bb_y_min = rc.ymin[CW-1:0]; bb_y_max = rc.ymax[CW-1:0];
          bb_valid = 1;
          @(posedge clk); #1;
          bb_valid = rc.spur;  // stray pulse outside WAIT_BB must be ignored
          bb_x_min = '0; bb_x_max = 16'd9; bb_y_min = '0; bb_y_max = 16'd9;
          @(posedge clk); #1;
          bb_valid = 0;
        end
      end
    end
  end

  // Downstream ready: always, 1-0-0 pattern, or random.
  initial begin
    pix_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (pat % 3 == 0);
        default: pix_ready = ($urandom_range(0, 2) != 0);
      endcase
      pat++;
    end
  end

  task automatic add_cfg(input int xmin, input int xmax, input int ymin, input int ymax,
                         input int dly, input bit resp, input bit spur);
    cfgq.push_back('{xmin, xmax, ymin, ymax, dly, resp, spur});
  endtask

  task automatic send_tris(input int n);
    int g;
    logic [159:0] r;
    @(posedge clk); #1;
    tri_in_valid = 1;
    for (int i = 0; i < n; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      tri_in = r[143:0];
      g = 0;
      do begin @(negedge clk); g++; end while (!tri_in_ready && g < 400);
      chk("accept_wait", tri_in_ready, 1);
      @(posedge clk); #1;
    end
    tri_in_valid = 0;
  endtask

  task automatic wait_retired(input int tgt, input string nm);
    int g = 0;
    while (retired < tgt && g < 3000) begin @(posedge clk); g++; end
    chk({nm, "_retire"}, retired >= tgt, 1);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 areset = 1;
    repeat (2) @(posedge clk);
    #1 areset = 0;
  endtask

  int ex_x[6] = '{2, 3, 4, 2, 3, 4};
  int ex_y[6] = '{7, 7, 7, 8, 8, 8};
  int base, g;
  cfg_t c;
  int w, h, k;

  initial begin
    areset = 1; tri_in = '0; tri_in_valid = 0; retired = 0; en_cnt = 0;
    repeat (3) @(posedge clk);
    #1 areset = 0;

    // 1) 3x2 box, ready always high
    rdy_mode = 0; obs.delete(); base = retired;
    add_cfg(2, 4, 7, 8, 11, 1, 0);
    send_tris(1);
    wait_retired(base + 1, "t1");
    chk("t1_npix", obs.size(), 6);
    for (int i = 0; i < 6 && i < obs.size(); i++)
      chk("t1_pix", {obs[i].x, obs[i].y, obs[i].last}, {ex_x[i], ex_y[i], (i == 5)});
    chk("t1_count", tri_count, 1);

    // 2) same box with stalls
    rdy_mode = 1; obs.delete(); base = retired;
    add_cfg(2, 4, 7, 8, 5, 1, 1);
    send_tris(1);
    wait_retired(base + 1, "t2");
    chk("t2_npix", obs.size(), 6);
    for (int i = 0; i < 6 && i < obs.size(); i++)
      chk("t2_pix", {obs[i].x, obs[i].y}, {ex_x[i], ex_y[i]});
    chk("t2_count", tri_count, 2);

    // 3) single pixel, then inverted x box
    rdy_mode = 0; obs.delete(); base = retired;
    add_cfg(5, 5, 0, 0, 2, 1, 0);
    add_cfg(9, 3, 0, 0, 4, 1, 0);
    send_tris(2);
    wait_retired(base + 2, "t3");
    chk("t3_npix", obs.size(), 1);
    if (obs.size() > 0) chk("t3_pix", {obs[0].x, obs[0].y, obs[0].last}, {32'd5, 32'd0, 1'b1});
    chk("t3_count", tri_count, 4);

    // 4) no bounds returned -> timeout, then a normal triangle
    obs.delete(); base = retired;
    add_cfg(0, 0, 0, 0, 1, 0, 0);
    send_tris(1);
    wait_retired(base + 1, "t4");
    chk("t4_timeout", bb_timeout, 1);
    chk("t4_count", tri_count, 4);
    add_cfg(0, 1, 0, 0, 3, 1, 0);
    send_tris(1);
    wait_retired(base + 2, "t4b");
    chk("t4b_npix", obs.size(), 2);
    chk("t4b_count", tri_count, 5);

    // 5) reset while the third of six pixels is presented
    obs.delete(); base = retired;
    add_cfg(2, 4, 7, 8, 3, 1, 0);
    send_tris(1);
    g = 0;
    while (obs.size() < 2 && g < 500) begin @(posedge clk); g++; end
    chk("t5_reach_px3", obs.size(), 2);
    #1 areset = 1;
    @(posedge clk); @(posedge clk);
    #1 areset = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("t5_no_more_pix", obs.size(), 2);
    chk("t5_count", tri_count, 0);
    chk("t5_busy", busy, 0);
    obs.delete(); base = retired;
    add_cfg(0, 1, 3, 3, 2, 1, 0);
    send_tris(1);
    wait_retired(base + 1, "t5b");
    chk("t5b_pix", {obs.size() == 2 ? {obs[0].x, obs[0].y, obs[1].x, obs[1].y} : 128'd0},
        {32'd0, 32'd3, 32'd1, 32'd3});
    chk("t5b_count", tri_count, 1);

    // 6) three triangles queued with valid held high
    pulse_reset();
    en_cnt = 0; base = retired;
    add_cfg(0, 2, 0, 1, 4, 1, 0);
    add_cfg(7, 6, 0, 0, 2, 1, 1);
    add_cfg(1, 1, 1, 1, 6, 1, 0);
    send_tris(3);
    wait_retired(base + 3, "t6");
    chk("t6_bb_en", en_cnt, 3);
    chk("t6_count", tri_count, 3);

    // random mix including a box that ends at x=y=0xFFFF
    rdy_mode = 2; base = retired;
    add_cfg(65534, 65535, 65535, 65535, 3, 1, 0);
    for (int i = 0; i < 30; i++) begin
      w = $urandom_range(0, 4); h = $urandom_range(0, 3); k = $urandom_range(0, 9);
      c.xmin = $urandom_range(5, 200); c.ymin = $urandom_range(0, 200);
      c.xmax = c.xmin + w; c.ymax = c.ymin + h;
      if (k == 0) c.xmax = c.xmin - 1 - $urandom_range(0, 3);
      if (k == 1) c.ymin = c.ymax + 1;
      if (k == 2) begin c.xmax = 65535; c.xmin = 65535 - w; end
      c.resp = (k != 3);
      c.dly  = $urandom_range(1, 20);
      c.spur = ($urandom_range(0, 3) == 0);
      add_cfg(c.xmin, c.xmax, c.ymin, c.ymax, c.dly, c.resp, c.spur);
    end
    send_tris(31);
    wait_retired(base + 31, "rand");
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
